map_table: RTL and testbench
============================

// Module: map_table
// PURPOSE
//   R10K-style register map table: maps each architectural register to its
//   current physical register tag, plus a ready ("+") bit.
//   Sits in dispatch/rename. Two source reads per cycle give operand tags to the RS.
//   One dest write per cycle renames a register and returns the old tag (T_old) to the ROB.
//   A CDB port sets ready bits when a producing tag completes.
// PARAMETERS
//   NUM_ARCH_REGS  32  architectural registers; index width is $clog2 = 5 bits
//   PHYS_REG_SZ    64  physical registers; TAG.tag width = $clog2(PHYS_REG_SZ)
//   TAG (sys_defs.svh) = packed struct {tag[$clog2(PHYS_REG_SZ)-1:0], valid}
//   TAG.valid = value ready (completed / committed)
// PORTS
//   clock       in   1     system clock; all state updates on posedge
//   reset       in   1     synchronous, active-high
//   read_idx_1  in   5     source register 1 index
//   read_idx_2  in   5     source register 2 index
//   read_out_1  out  TAG   mapping of read_idx_1
//   read_out_2  out  TAG   mapping of read_idx_2
//   write_en    in   1     rename destination this cycle
//   write_idx   in   5     destination architectural register
//   write_tag   in   TAG   new mapping; valid normally 0 for a freshly allocated preg
//   write_out   out  TAG   current (old) mapping of write_idx = T_old
//   cdb_en      in   1     CDB broadcast valid; tie to 0 when unused
//   cdb_tag     in   TAG   completing physical tag; only .tag is compared
// BEHAVIOUR
//   Storage
//   - Array table[NUM_ARCH_REGS] of TAG.
//   Reset
//   - On a posedge with reset=1: table[i] = {tag:i, valid:1} for all i.
//   - Reset overrides write_en and cdb_en.
//   - Reset mid-operation discards all renames.
//   - Outputs are combinational, so they show the reset mapping from the next
//     cycle onward (e.g. read_out_1 for idx 1 = {1,1}).
//   Reads (read_out_1, read_out_2, write_out)
//   - Combinational from table; zero latency.
//   - A same-cycle write is NOT forwarded: outputs show the pre-edge mapping.
//     This makes write_out the true T_old.
//   - CDB bypass: if cdb_en and cdb_tag.tag == table[idx].tag, the output's
//     .valid is forced to 1 in that same cycle. Applies to all three outputs.
//   Write
//   - At posedge, if write_en and write_idx != 0: table[write_idx] <= write_tag,
//     stored as given including .valid.
//   - Register 0 is hardwired: writes to idx 0 are ignored.
//     Reads of idx 0 always return {0,1}. write_out for idx 0 returns {0,1}.
//   CDB
//   - At posedge, if cdb_en: every entry with .tag == cdb_tag.tag gets valid <= 1.
//     Associative over all entries.
//   Simultaneous events
//   - write_en and cdb_en on the same index in one cycle: the write wins.
//     Entry = write_tag, because the new mapping supersedes the completing one.
//   - write and reads of the same index in one cycle: reads get the old value.
//   Other
//   - No handshake and no stall: the table accepts one write every cycle.
//   - X on write_en while not in reset is illegal; the bench must drive 0.
// TESTING
//   1. Reset, then read_idx_1=1, read_idx_2=2 -> read_out_1={1,1}, read_out_2={2,1}.
//   2. Read idx 10/12 -> {10,1}/{12,1}.
//      Then read idx 0 -> {0,1}.
//   3. write_en=1, write_idx=2, write_tag={5,0}:
//      - same cycle: write_out={2,1};
//      - next cycle: read_idx_2=2 -> {5,0}, write_out={5,0}.
//   4. After test 3, cdb_en=1, cdb_tag.tag=5:
//      - same cycle: read of idx 2 -> {5,1} (bypass);
//      - after the edge, with cdb_en=0: {5,1} stored.
//   5. Same cycle write idx 3 <- {40,0} and cdb_tag.tag=3 -> next cycle idx 3 = {40,0}.
//      Write to idx 0 -> read idx 0 stays {0,1}.
//   6. Rename several regs, then assert reset -> all entries back to {i,1} on the next cycle.

Source files
------------

// File: rtl/map_table.sv
// R10K-style register map table.
// Maps each architectural register to its current physical tag plus a ready bit.
// Lookups are combinational. A rename in the same cycle is not forwarded, so
// write_out is the true T_old. A CDB broadcast is bypassed into the ready bit
// of all three lookups in the cycle it arrives.
// Each tag port is a packed {tag, valid} vector: bits [TAG_W:1] hold the tag
// and bit [0] holds valid.
module map_table #(
   parameter  int NUM_ARCH_REGS = 32,
   parameter  int PHYS_REG_SZ   = 64,
   localparam int IDX_W         = $clog2(NUM_ARCH_REGS),
   localparam int TAG_W         = $clog2(PHYS_REG_SZ),
   localparam int ENTRY_W       = TAG_W + 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [IDX_W-1:0]   read_idx_1,
   input  logic [IDX_W-1:0]   read_idx_2,
   output logic [ENTRY_W-1:0] read_out_1,
   output logic [ENTRY_W-1:0] read_out_2,
   input  logic               write_en,
   input  logic [IDX_W-1:0]   write_idx,
   input  logic [ENTRY_W-1:0] write_tag,
   output logic [ENTRY_W-1:0] write_out,
   input  logic               cdb_en,
   input  logic [ENTRY_W-1:0] cdb_tag
);

   // Register 0 always maps to physical tag 0, which is always ready.
   localparam logic [ENTRY_W-1:0] ZERO_ENTRY = {{TAG_W{1'b0}}, 1'b1};

   logic [ENTRY_W-1:0] table_reg  [NUM_ARCH_REGS];
   logic [ENTRY_W-1:0] table_next [NUM_ARCH_REGS];

   // Per-entry match strobes.
   logic [NUM_ARCH_REGS-1:0] write_hit;
   logic [NUM_ARCH_REGS-1:0] cdb_hit;

   // Only the tag field of a CDB broadcast takes part in matching.
   logic [TAG_W-1:0] cdb_match_tag;
   logic             cdb_valid_unused;

   assign cdb_match_tag    = cdb_tag[ENTRY_W-1:1];
   assign cdb_valid_unused = cdb_tag[0];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_ARCH_REGS; gi++) begin : g_match
         if (gi == 0) begin : g_zero
            // Writes to register 0 are ignored, and its ready bit is already set.
            assign write_hit[gi] = 1'b0;
            assign cdb_hit[gi]   = 1'b0;
         end else begin : g_entry
            // A rename targets exactly one entry.
            assign write_hit[gi] = write_en && (write_idx == IDX_W'(gi));
            // A completion may match several entries.
            assign cdb_hit[gi]   = cdb_en && (table_reg[gi][ENTRY_W-1:1] == cdb_match_tag);
         end
      end
   endgenerate

   // Next-state for every entry. The write takes priority over the CDB because
   // the new mapping supersedes the one that is completing.
   always_comb begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) begin
         table_next[i] = table_reg[i];
         if (i == 0) begin
            table_next[i] = ZERO_ENTRY;
         end else if (write_hit[i]) begin
            table_next[i] = write_tag;
         end else if (cdb_hit[i]) begin
            table_next[i][0] = 1'b1;
         end
      end
   end

   // Table state. Reset restores the identity mapping with every entry ready,
   // and it discards any rename or CDB update in flight.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) begin
         if (reset) begin
            table_reg[i] <= {TAG_W'(i), 1'b1};
         end else begin
            table_reg[i] <= table_next[i];
         end
      end
   end

   // Combinational lookup. It returns the pre-edge mapping and applies the CDB
   // ready bypass. Register 0 is forced to tag 0, ready.
   function automatic logic [ENTRY_W-1:0] lookup(input logic [IDX_W-1:0] idx);
      logic [ENTRY_W-1:0] e;
      e = table_reg[idx];
      if (idx == '0) begin
         e = ZERO_ENTRY;
      end else if (cdb_en && (e[ENTRY_W-1:1] == cdb_match_tag)) begin
         e[0] = 1'b1;
      end
      return e;
   endfunction

   // Two source-operand lookups plus the T_old lookup for the destination.
   always_comb begin
      read_out_1 = lookup(read_idx_1);
      read_out_2 = lookup(read_idx_2);
      write_out  = lookup(write_idx);
   end

endmodule

// File: tb/tb_map_table.sv
// Directed testbench for map_table.
// Inputs are driven 1 time unit after each rising edge. The combinational
// outputs are checked before the next rising edge.
module tb_map_table;

   localparam int TAG_W   = 6;
   localparam int ENTRY_W = TAG_W + 1;

   logic               clock;
   logic               reset;
   logic [4:0]         read_idx_1;
   logic [4:0]         read_idx_2;
   logic [ENTRY_W-1:0] read_out_1;
   logic [ENTRY_W-1:0] read_out_2;
   logic               write_en;
   logic [4:0]         write_idx;
   logic [ENTRY_W-1:0] write_tag;
   logic [ENTRY_W-1:0] write_out;
   logic               cdb_en;
   logic [ENTRY_W-1:0] cdb_tag;

   int checks_cnt;
   int errors_cnt;

   map_table #(.NUM_ARCH_REGS(32), .PHYS_REG_SZ(64)) dut (
      .clock      (clock),
      .reset      (reset),
      .read_idx_1 (read_idx_1),
      .read_idx_2 (read_idx_2),
      .read_out_1 (read_out_1),
      .read_out_2 (read_out_2),
      .write_en   (write_en),
      .write_idx  (write_idx),
      .write_tag  (write_tag),
      .write_out  (write_out),
      .cdb_en     (cdb_en),
      .cdb_tag    (cdb_tag)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Pack a {tag, valid} value.
   function automatic logic [ENTRY_W-1:0] mk(input int t, input logic v);
      return {TAG_W'(t), v};
   endfunction

   task automatic check_val(input string tag, input logic [ENTRY_W-1:0] actual,
                            input logic [ENTRY_W-1:0] expected);
      checks_cnt++;
      if (actual !== expected) begin
         errors_cnt++;
         $display("FAIL %s: got tag=%0d valid=%0b, expected tag=%0d valid=%0b",
                  tag, actual[ENTRY_W-1:1], actual[0], expected[ENTRY_W-1:1], expected[0]);
      end else begin
         $display("ok   %s: tag=%0d valid=%0b", tag, actual[ENTRY_W-1:1], actual[0]);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      checks_cnt = 0;
      errors_cnt = 0;
      reset      = 1'b1;
      read_idx_1 = '0;
      read_idx_2 = '0;
      write_en   = 1'b0;
      write_idx  = '0;
      write_tag  = '0;
      cdb_en     = 1'b0;
      cdb_tag    = '0;
      tick();
      tick();
      reset = 1'b0;

      // Test 1: identity mapping after reset.
      read_idx_1 = 5'd1; read_idx_2 = 5'd2; #1;
      check_val("rst_r1_idx1", read_out_1, mk(1, 1'b1));
      check_val("rst_r2_idx2", read_out_2, mk(2, 1'b1));

      // Test 2: other indices, and register 0.
      read_idx_1 = 5'd10; read_idx_2 = 5'd12; #1;
      check_val("rd_idx10", read_out_1, mk(10, 1'b1));
      check_val("rd_idx12", read_out_2, mk(12, 1'b1));
      read_idx_1 = 5'd0; #1;
      check_val("rd_idx0", read_out_1, mk(0, 1'b1));

      // Test 3: rename r2 -> p5. The same cycle still shows the old mapping.
      write_en = 1'b1; write_idx = 5'd2; write_tag = mk(5, 1'b0);
      read_idx_2 = 5'd2; #1;
      check_val("told_same_cycle", write_out, mk(2, 1'b1));
      check_val("rd_no_forward", read_out_2, mk(2, 1'b1));
      tick();
      write_en = 1'b0; #1;
      check_val("rd_after_write", read_out_2, mk(5, 1'b0));
      check_val("wout_after_write", write_out, mk(5, 1'b0));

      // Test 4: CDB p5. The bypass applies in the same cycle, and the bit is
      // stored at the edge. The CDB valid bit is deliberately 0 (ignored).
      cdb_en = 1'b1; cdb_tag = mk(5, 1'b0); #1;
      check_val("cdb_bypass_r2", read_out_2, mk(5, 1'b1));
      check_val("cdb_bypass_wout", write_out, mk(5, 1'b1));
      tick();
      cdb_en = 1'b0; #1;
      check_val("cdb_stored", read_out_2, mk(5, 1'b1));

      // Test 5: write and CDB on the same entry in one cycle; the write wins.
      write_en = 1'b1; write_idx = 5'd3; write_tag = mk(40, 1'b0);
      cdb_en = 1'b1; cdb_tag = mk(3, 1'b0); read_idx_1 = 5'd3; #1;
      check_val("told_r3", write_out, mk(3, 1'b1));
      tick();
      write_en = 1'b0; cdb_en = 1'b0; #1;
      check_val("write_wins_cdb", read_out_1, mk(40, 1'b0));

      // A write to register 0 is ignored.
      write_en = 1'b1; write_idx = 5'd0; write_tag = mk(9, 1'b0); #1;
      check_val("wout_idx0", write_out, mk(0, 1'b1));
      tick();
      write_en = 1'b0; read_idx_1 = 5'd0; #1;
      check_val("idx0_hardwired", read_out_1, mk(0, 1'b1));

      // Associative CDB: r4 and r5 both map to p20, and r6 maps to p30.
      write_en = 1'b1; write_idx = 5'd4; write_tag = mk(20, 1'b0); tick();
      write_idx = 5'd5; write_tag = mk(20, 1'b0); tick();
      write_idx = 5'd6; write_tag = mk(30, 1'b0); tick();
      write_en = 1'b0; cdb_en = 1'b1; cdb_tag = mk(31, 1'b1);
      read_idx_1 = 5'd6; #1;
      check_val("cdb_nomatch_bypass", read_out_1, mk(30, 1'b0));
      tick();
      cdb_tag = mk(20, 1'b0); read_idx_1 = 5'd4; read_idx_2 = 5'd5; tick();
      cdb_en = 1'b0; #1;
      check_val("cdb_assoc_r4", read_out_1, mk(20, 1'b1));
      check_val("cdb_assoc_r5", read_out_2, mk(20, 1'b1));
      read_idx_1 = 5'd6; #1;
      check_val("cdb_nomatch_r6", read_out_1, mk(30, 1'b0));

      // Test 6: reset overrides a write and a CDB broadcast in the same cycle.
      // After it, every entry is the identity mapping again.
      reset = 1'b1; write_en = 1'b1; write_idx = 5'd7; write_tag = mk(50, 1'b0);
      cdb_en = 1'b1; cdb_tag = mk(50, 1'b0); tick();
      reset = 1'b0; write_en = 1'b0; cdb_en = 1'b0;
      for (int i = 0; i < 32; i++) begin
         read_idx_1 = 5'(i); #1;
         check_val($sformatf("reset_entry%0d", i), read_out_1, mk(i, 1'b1));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
